// File: rtl/wave_layer_engine_if.sv
// Pixel/config bus for wave_layer_engine.
//   master: drives the timing-generator pixel stream (x, y, frame_active,
//           frame_start) and palette writes (cfg_we, cfg_addr, cfg_data);
//           receives the registered 2-bit-per-channel colour (r, g, b).
//   slave : the renderer side of the same signals.
interface wave_layer_engine_if;
  logic [9:0] x;
  logic [8:0] y;
  logic       frame_active;
  logic       frame_start;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [5:0] cfg_data;
  logic [1:0] r;
  logic [1:0] g;
  logic [1:0] b;

  modport master (
    output x, y, frame_active, frame_start, cfg_we, cfg_addr, cfg_data,
    input  r, g, b
  );

  modport slave (
    input  x, y, frame_active, frame_start, cfg_we, cfg_addr, cfg_data,
    output r, g, b
  );
endinterface

// File: rtl/wave_layer_engine.sv
// Composites NUM_LAYERS scrolling, dithered sine-wave layers through a
// double-buffered palette and applies a frame-synchronous fade.
// Ports:
//   clk, rst_n : pixel clock, synchronous active-low reset
//   vid        : pixel stream + palette writes in, registered r/g/b out
//   enable     : 1 = fade in / stay on, 0 = fade out / stay off
//   pause      : freezes the animation counter
//   level      : current brightness 0..3
//   busy       : high while fading
module wave_layer_engine #(
  parameter int unsigned NUM_LAYERS  = 2,
  parameter int unsigned CTR_BITS    = 10,
  parameter int unsigned FADE_FRAMES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wave_layer_engine_if.slave   vid,
  input  logic                 enable,
  input  logic                 pause,
  output logic [1:0]           level,
  output logic                 busy
);

  typedef enum logic [1:0] {S_OFF, S_FADE_IN, S_ON, S_FADE_OUT} state_t;

  state_t              state_q, state_d;
  logic [1:0]          level_q, level_d;
  logic [7:0]          tick_q, tick_d;
  logic [CTR_BITS-1:0] ctr_q;
  logic [5:0]          shadow_q  [NUM_LAYERS];
  logic [5:0]          shadow_nx [NUM_LAYERS];
  logic [5:0]          active_q  [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] hit;
  logic [5:0]          col;
  logic [1:0]          atten;

  function automatic logic [5:0] pal_default(input int unsigned i);
    case (i)
      0:       pal_default = 6'b00_11_11;
      1:       pal_default = 6'b11_00_11;
      2:       pal_default = 6'b11_11_00;
      default: pal_default = 6'b01_01_11;
    endcase
  endfunction

  // 16 + round(15*sin(2*pi*p/64)) folded onto a quarter-wave table.
  function automatic logic [4:0] wave_h(input logic [5:0] p);
    logic [4:0] k;
    logic [3:0] q;
    k = p[4] ? (5'd16 - {1'b0, p[3:0]}) : {1'b0, p[3:0]};
    case (k)
      5'd0:    q = 4'd0;
      5'd1:    q = 4'd1;
      5'd2:    q = 4'd3;
      5'd3:    q = 4'd4;
      5'd4:    q = 4'd6;
      5'd5:    q = 4'd7;
      5'd6:    q = 4'd8;
      5'd7:    q = 4'd10;
      5'd8:    q = 4'd11;
      5'd9:    q = 4'd12;
      5'd10:   q = 4'd12;
      5'd11:   q = 4'd13;
      5'd12:   q = 4'd14;
      5'd13:   q = 4'd14;
      default: q = 4'd15;
    endcase
    wave_h = p[5] ? (5'd16 - {1'b0, q}) : (5'd16 + {1'b0, q});
  endfunction

  function automatic logic [1:0] dim(input logic [1:0] c, input logic [1:0] a);
    dim = (c > a) ? (c - a) : 2'd0;
  endfunction

  // A write landing on the frame_start cycle must reach the active copy.
  always_comb begin
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      shadow_nx[i] = shadow_q[i];
      if (vid.cfg_we && (vid.cfg_addr == 2'(i)))
        shadow_nx[i] = vid.cfg_data;
    end
  end

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
    logic [9:0] ax;
    logic [5:0] phase;
    logic [4:0] ry;
    logic       mask;
    always_comb begin
      ax    = vid.x + (ctr_q[9:0] << i);
      phase = ax[8-i:3-i];
      ry    = vid.y[8-i:4-i];
      mask  = (i == 0) ? (vid.x[0] ^ vid.y[0]) : (vid.x[0] & vid.y[0]);
      hit[i] = (ry > wave_h(phase)) & mask;
    end
  end

  always_comb begin
    logic found;
    col   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (hit[i] && !found) begin
        col   = active_q[i];
        found = 1'b1;
      end
    end
    if (!vid.frame_active)
      col = '0;
    atten = 2'd3 - level_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctr_q <= '0;
      vid.r <= '0;
      vid.g <= '0;
      vid.b <= '0;
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
        shadow_q[i] <= pal_default(i);
        active_q[i] <= pal_default(i);
      end
    end else begin
      if (vid.frame_start && !pause)
        ctr_q <= ctr_q + 1'b1;
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
        shadow_q[i] <= shadow_nx[i];
        if (vid.frame_start)
          active_q[i] <= shadow_nx[i];
      end
      vid.r <= dim(col[5:4], atten);
      vid.g <= dim(col[3:2], atten);
      vid.b <= dim(col[1:0], atten);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      level_q <= '0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    tick_d  = tick_q;
    busy    = 1'b0;
    case (state_q)
      S_OFF: begin
        level_d = '0;
        if (enable) begin
          state_d = S_FADE_IN;
          tick_d  = '0;
        end
      end
      S_FADE_IN: begin
        busy = 1'b1;
        if (!enable) begin
          state_d = S_FADE_OUT;
          tick_d  = '0;
        end else if (vid.frame_start) begin
          if (tick_q == 8'(FADE_FRAMES - 1)) begin
            tick_d  = '0;
            level_d = level_q + 1'b1;
            if (level_q == 2'd2)
              state_d = S_ON;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_ON: begin
        level_d = 2'd3;
        if (!enable) begin
          state_d = S_FADE_OUT;
          tick_d  = '0;
        end
      end
      default: begin
        busy = 1'b1;
        if (enable) begin
          state_d = S_FADE_IN;
          tick_d  = '0;
        end else if (vid.frame_start) begin
          if (tick_q == 8'(FADE_FRAMES - 1)) begin
            tick_d  = '0;
            level_d = level_q - 1'b1;
            if (level_q == 2'd1)
              state_d = S_OFF;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
    endcase
  end

  assign level = level_q;

endmodule

// File: tb/tb_wave_layer_engine.sv
// Scoreboard bench for wave_layer_engine (NUM_LAYERS=2, FADE_FRAMES=2).
// Each stimulus cycle may push the outputs expected just after the next
// rising edge; the monitor pops and compares whenever a probe is flagged.
module tb_wave_layer_engine;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic pause;
  logic [1:0] level;
  logic busy;

  wave_layer_engine_if vif ();

  wave_layer_engine #(
    .NUM_LAYERS  (2),
    .CTR_BITS    (10),
    .FADE_FRAMES (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .vid    (vif),
    .enable (enable),
    .pause  (pause),
    .level  (level),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic [1:0] lvl;
    logic       bsy;
  } exp_t;

  exp_t exp_q[$];
  logic probe = 1'b0;
  int   n_pass = 0;
  int   n_tot  = 0;

  logic       rst_v = 1'b0;
  logic       en_v  = 1'b0;
  logic       pa_v  = 1'b1;
  logic [1:0] cur_lvl = 2'd0;
  logic       cur_bsy = 1'b0;

  // Monitor: compares DUT outputs 1 time unit after a probed edge.
  always @(posedge clk) begin
    if (probe) begin
      exp_t e;
      #1;
      n_tot++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_underflow: output probed with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        if (vif.r === e.r && vif.g === e.g && vif.b === e.b &&
            level === e.lvl && busy === e.bsy)
          n_pass++;
        else
          $display("FAIL %s: got rgb=%0d,%0d,%0d level=%0d busy=%0d, expected rgb=%0d,%0d,%0d level=%0d busy=%0d",
                   e.name, vif.r, vif.g, vif.b, level, busy, e.r, e.g, e.b, e.lvl, e.bsy);
      end
    end
  end

  task automatic step(input logic [9:0] xi, input logic [8:0] yi,
                      input logic fa, input logic fs,
                      input logic we, input logic [1:0] wa, input logic [5:0] wd,
                      input bit chk, input string nm,
                      input logic [1:0] er, input logic [1:0] eg, input logic [1:0] eb);
    @(negedge clk);
    rst_n            = rst_v;
    enable           = en_v;
    pause            = pa_v;
    vif.x            = xi;
    vif.y            = yi;
    vif.frame_active = fa;
    vif.frame_start  = fs;
    vif.cfg_we       = we;
    vif.cfg_addr     = wa;
    vif.cfg_data     = wd;
    probe            = chk;
    if (chk)
      exp_q.push_back('{nm, er, eg, eb, cur_lvl, cur_bsy});
  endtask

  task automatic frame(input int n);
    for (int i = 0; i < n; i++)
      step(10'd0, 9'd0, 1'b0, 1'b1, 1'b0, 2'd0, 6'd0, 1'b0, "", 2'd0, 2'd0, 2'd0);
  endtask

  task automatic st(input string nm, input logic [1:0] l, input logic bz);
    cur_lvl = l;
    cur_bsy = bz;
    step(10'd0, 9'd0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 1'b1, nm, 2'd0, 2'd0, 2'd0);
  endtask

  task automatic px(input logic [9:0] xi, input logic [8:0] yi, input string nm,
                    input logic [1:0] er, input logic [1:0] eg, input logic [1:0] eb);
    step(xi, yi, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0, 1'b1, nm, er, eg, eb);
  endtask

  task automatic wr(input logic [1:0] wa, input logic [5:0] wd, input logic fs);
    step(10'd0, 9'd0, 1'b0, fs, 1'b1, wa, wd, 1'b0, "", 2'd0, 2'd0, 2'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset with random activity on the inputs.
    rst_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en_v = 1'($urandom);
      pa_v = 1'($urandom);
      cur_lvl = 2'd0;
      cur_bsy = 1'b0;
      step(10'($urandom), 9'($urandom), 1'($urandom), 1'($urandom),
           1'b0, 2'd0, 6'd0, (i == 2), "reset", 2'd0, 2'd0, 2'd0);
    end
    rst_v = 1'b1;
    en_v  = 1'b0;
    pa_v  = 1'b1;
    st("idle_off", 2'd0, 1'b0);

    // Fade in to level 2, then fade out to OFF.
    en_v = 1'b1;
    st("fade_in_entry", 2'd0, 1'b1);
    frame(1); st("fade_in_tick1", 2'd0, 1'b1);
    frame(1); st("fade_in_l1", 2'd1, 1'b1);
    frame(2); st("fade_in_l2", 2'd2, 1'b1);
    en_v = 1'b0;
    st("fade_out_entry", 2'd2, 1'b1);
    frame(1); st("fade_out_tick1", 2'd2, 1'b1);
    frame(1); st("fade_out_l1", 2'd1, 1'b1);
    frame(2); st("fade_out_off", 2'd0, 1'b0);
    en_v = 1'b1;
    st("fade_in2_entry", 2'd0, 1'b1);
    frame(4); st("fade_in2_l2", 2'd2, 1'b1);
    frame(1); st("fade_in2_l2_tick", 2'd2, 1'b1);
    frame(1); st("on", 2'd3, 1'b0);

    // Rendering at ctr=0, level 3, default palette.
    px(10'd1,   9'd272, "l0_basic",    2'd0, 2'd3, 2'd3);
    px(10'd0,   9'd272, "mask_off",    2'd0, 2'd0, 2'd0);
    step(10'd1, 9'd272, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 1'b1, "blanking", 2'd0, 2'd0, 2'd0);
    px(10'd1,   9'd137, "l1_basic",    2'd3, 2'd0, 2'd3);
    px(10'd1,   9'd400, "both_raw_l0", 2'd0, 2'd3, 2'd3);
    px(10'd1,   9'd401, "both_raw_l1", 2'd3, 2'd0, 2'd3);
    px(10'd129, 9'd496, "h16_top",     2'd0, 2'd0, 2'd0);
    px(10'd385, 9'd32,  "h48_above",   2'd0, 2'd3, 2'd3);
    px(10'd385, 9'd16,  "h48_equal",   2'd0, 2'd0, 2'd0);
    px(10'd65,  9'd432, "h8_equal",    2'd0, 2'd0, 2'd0);
    px(10'd65,  9'd448, "h8_above",    2'd0, 2'd3, 2'd3);
    px(10'd63,  9'd432, "ctr0_ph7",    2'd0, 2'd3, 2'd3);

    // Palette double-buffering.
    wr(2'd0, 6'b11_00_00, 1'b0);
    px(10'd1, 9'd272, "pal_shadow_only", 2'd0, 2'd3, 2'd3);
    frame(1);
    px(10'd1, 9'd272, "pal_copied",      2'd3, 2'd0, 2'd0);
    wr(2'd0, 6'b01_01_01, 1'b1);
    px(10'd1, 9'd272, "pal_same_cycle",  2'd1, 2'd1, 2'd1);
    wr(2'd3, 6'b00_00_01, 1'b0);
    frame(1);
    px(10'd1, 9'd272, "pal_addr3_l0",    2'd1, 2'd1, 2'd1);
    px(10'd1, 9'd401, "pal_addr3_l1",    2'd3, 2'd0, 2'd3);

    // Animation counter: scroll, pause, wrap.
    pa_v = 1'b0;
    frame(1);
    px(10'd63, 9'd432, "ctr1_l0_shift", 2'd0, 2'd0, 2'd0);
    px(10'd62, 9'd433, "ctr1_l0_ph7",   2'd1, 2'd1, 2'd1);
    pa_v = 1'b1;
    frame(5);
    px(10'd62, 9'd433, "pause_hold_in",  2'd1, 2'd1, 2'd1);
    px(10'd63, 9'd432, "pause_hold_out", 2'd0, 2'd0, 2'd0);
    pa_v = 1'b0;
    frame(1);
    px(10'd27, 9'd217, "ctr2_l1_in",  2'd3, 2'd0, 2'd3);
    px(10'd29, 9'd217, "ctr2_l1_out", 2'd0, 2'd0, 2'd0);
    px(10'd61, 9'd432, "ctr2_l0_in",  2'd1, 2'd1, 2'd1);
    frame(1021);
    px(10'd1,  9'd432, "ctr1023_l0",  2'd1, 2'd1, 2'd1);
    px(10'd65, 9'd432, "ctr1023_out", 2'd0, 2'd0, 2'd0);
    frame(1);
    px(10'd63, 9'd432, "ctr_wrap_l0", 2'd1, 2'd1, 2'd1);

    // Fade out from ON, dimming, reversal, reset mid-fade.
    pa_v = 1'b1;
    en_v = 1'b0;
    st("fade_out_from_on", 2'd3, 1'b1);
    frame(2); st("fade_out_l2", 2'd2, 1'b1);
    frame(2); st("fade_out_l1b", 2'd1, 1'b1);
    px(10'd1, 9'd401, "dim_l1_layer1", 2'd1, 2'd0, 2'd1);
    px(10'd1, 9'd272, "dim_l1_clamp",  2'd0, 2'd0, 2'd0);
    en_v = 1'b1;
    st("reverse_keep_level", 2'd1, 1'b1);
    frame(1);
    rst_v = 1'b0;
    st("reset_mid_fade", 2'd0, 1'b0);
    rst_v = 1'b1;
    st("post_reset_fade_in", 2'd0, 1'b1);
    frame(2); st("fade_in3_l1", 2'd1, 1'b1);
    px(10'd1, 9'd272, "dim_default_pal", 2'd0, 2'd1, 2'd1);
    frame(4); st("on_again", 2'd3, 1'b0);
    px(10'd1, 9'd272, "default_pal_restored", 2'd0, 2'd3, 2'd3);

    step(10'd0, 9'd0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0, "", 2'd0, 2'd0, 2'd0);
    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_tot++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
